// File: rtl/cpu_defs_pkg.sv
// Shared EX-stage definitions: datapath widths, ALUOp and funct encodings,
// and the state encoding of the iterative multiplier.
package cpu_defs_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative 32x32 multiplier: latches both operands on start, then adds one
// 8-bit slice of the multiplier per cycle over four cycles (low 32 bits kept).
module ex_mul_iter
    import cpu_defs_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    logic [1:0]        state;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [7:0]        mul_byte;
    logic [DATA_W-1:0] partial;

    assign mul_byte = mplier[{cnt, 3'b000} +: 8];
    assign partial  = (mcand * {{(DATA_W-8){1'b0}}, mul_byte}) << {cnt, 3'b000};

    // NOTE: the datapath registers are reset too, so an abandoned multiply
    // leaves no stale operands or partial sum behind.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= MUL_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            case (state)
                MUL_IDLE: if (start) begin
                    mcand  <= op_a;
                    mplier <= op_b;
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= MUL_BUSY;
                end
                MUL_BUSY: begin
                    acc <= acc + partial;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) state <= MUL_DONE;
                end
                MUL_DONE: state <= MUL_IDLE;
                default:  state <= MUL_IDLE;
            endcase
        end
    end

    assign busy    = (state == MUL_BUSY);
    assign done    = (state == MUL_DONE);
    assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// EX pipeline stage: operand forwarding, ALU and the EX/MEM register.
// Define EX_MULT_EN to build the iterative multiplier (funct 0x18) with stall.
module ex_stage
    import cpu_defs_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [1:0]        WB_i,
    input  logic [1:0]        M_i,
    input  logic              ALUSrc_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              RegDst_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [5:0]        funct_i,
    input  logic [REG_W-1:0]  RSaddr_i,
    input  logic [REG_W-1:0]  RTaddr_i,
    input  logic [REG_W-1:0]  RDaddr_i,
    input  logic              wb_regwrite_i,
    input  logic [REG_W-1:0]  wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              valid_o,
    output logic [1:0]        WB_o,
    output logic [1:0]        M_o,
    output logic [DATA_W-1:0] ALUresult_o,
    output logic [DATA_W-1:0] WriteData_o,
    output logic [REG_W-1:0]  RDaddr_o,
    output logic              stall_o
);

    logic              mem_fwd_a, mem_fwd_b, wb_fwd_a, wb_fwd_b;
    logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_res, ex_res;
    logic [REG_W-1:0]  dest;

    // The younger producer in EX/MEM wins over MEM/WB; r0 is never forwarded.
    assign mem_fwd_a = valid_o && WB_o[1] && (RDaddr_o != '0) && (RDaddr_o == RSaddr_i);
    assign mem_fwd_b = valid_o && WB_o[1] && (RDaddr_o != '0) && (RDaddr_o == RTaddr_i);
    assign wb_fwd_a  = wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == RSaddr_i);
    assign wb_fwd_b  = wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == RTaddr_i);

    assign fwd_a = mem_fwd_a ? ALUresult_o : (wb_fwd_a ? wb_data_i : RSdata_i);
    assign fwd_b = mem_fwd_b ? ALUresult_o : (wb_fwd_b ? wb_data_i : RTdata_i);
    assign alu_b = ALUSrc_i ? imm_i : fwd_b;
    assign dest  = RegDst_i ? RDaddr_i : RTaddr_i;

    // NOTE: alu_res gets a default before the case so no path infers a latch.
    always_comb begin
        alu_res = '0;
        case (ALUOp_i)
            ALUOP_ADD: alu_res = fwd_a + alu_b;
            ALUOP_SUB: alu_res = fwd_a - alu_b;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alu_res = fwd_a + alu_b;
                    FUNCT_SUB: alu_res = fwd_a - alu_b;
                    FUNCT_AND: alu_res = fwd_a & alu_b;
                    FUNCT_OR:  alu_res = fwd_a | alu_b;
                    FUNCT_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
                    default:   alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MULT_EN
    logic              is_mul, mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_product;

    assign is_mul    = valid_i && (ALUOp_i == ALUOP_FUNCT) && (funct_i == FUNCT_MUL);
    // Gated by reset so stall_o reads 0 while reset is held.
    assign mul_start = is_mul && !rst_i;

    ex_mul_iter u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (mul_start),
        .op_a    (fwd_a),
        .op_b    (fwd_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign stall_o = (mul_start && !mul_busy && !mul_done) || mul_busy;
    assign ex_res  = mul_done ? mul_product : alu_res;
`else
    assign stall_o = 1'b0;
    assign ex_res  = alu_res;
`endif

    // Bubbles clear only the control fields; data fields keep their last value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o     <= 1'b0;
            WB_o        <= '0;
            M_o         <= '0;
            ALUresult_o <= '0;
            WriteData_o <= '0;
            RDaddr_o    <= '0;
        end else if (stall_o || !valid_i) begin
            valid_o <= 1'b0;
            WB_o    <= '0;
            M_o     <= '0;
        end else begin
            valid_o     <= 1'b1;
            WB_o        <= WB_i;
            M_o         <= M_i;
            ALUresult_o <= ex_res;
            WriteData_o <= fwd_b;
            RDaddr_o    <= dest;
        end
    end

endmodule
